// File: rtl/datapath_arbiter_pkg.sv
// Shared types for the datapath and its requesters: arbiter states, opcodes,
// register selects and the command bundle that drives the shared datapath.
package datapath_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    typedef logic [2:0] opcode_t;
    typedef logic [3:0] reg_sel_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MUL = 3'd6
    } opcode_e;

    localparam reg_sel_t REG_R0 = 4'd0;

    localparam int BURST_CNT_W = 8;
    typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

    typedef struct packed {
        opcode_t  op;
        reg_sel_t src1;
        reg_sel_t src2;
        reg_sel_t dest;
    } dp_cmd_t;

    localparam dp_cmd_t DP_CMD_NOP = '{
        op:   opcode_t'(OP_NOP),
        src1: REG_R0,
        src2: REG_R0,
        dest: REG_R0
    };

    // Winner among eligible requesters; a tie goes to whoever was not granted last.
    function automatic arb_state_t arbitrate(input logic elig0,
                                             input logic elig1,
                                             input logic last_gnt);
        arb_state_t result;
        result = ST_IDLE;
        if (elig0 && elig1) begin
            result = last_gnt ? ST_GRANT0 : ST_GRANT1;
        end else if (elig0) begin
            result = ST_GRANT0;
        end else if (elig1) begin
            result = ST_GRANT1;
        end
        return result;
    endfunction

endpackage

// File: rtl/datapath_arbiter_burst_timer.sv
// Burst length counter: restarts at 1 when a grant begins, counts each further
// granted cycle and flags when the burst has reached MAX_BURST.
module burst_timer
    import datapath_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_enable,
    output logic o_tc
);

    burst_cnt_t r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= burst_cnt_t'(1);
        end else if (i_enable && (r_count != '1)) begin
            // Saturates rather than wrapping; the arbiter releases well before this.
            r_count <= r_count + burst_cnt_t'(1);
        end
    end

    assign o_tc = (r_count == burst_cnt_t'(MAX_BURST));

endmodule

// File: rtl/datapath_arbiter.sv
// Two-requester arbiter for the shared datapath: round-robin on ties, bursts
// capped at MAX_BURST with a timeout that blocks the offender until it drops req.
module datapath_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [3:0] src1_0,
    input  logic [3:0] src2_0,
    input  logic [3:0] dest0,
    input  logic [3:0] src1_1,
    input  logic [3:0] src2_1,
    input  logic [3:0] dest1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       busy,
    output logic       err
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_block0;
    logic       r_block1;
    logic       r_last_gnt;
    logic       r_err;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_timeout;
    logic       w_tc;
    logic       w_timer_clear;
    logic       w_timer_load;
    logic       w_timer_enable;

    dp_cmd_t    w_cmd0;
    dp_cmd_t    w_cmd1;
    dp_cmd_t    w_cmd;

    assign w_elig0 = req0 && !r_block0;
    assign w_elig1 = req1 && !r_block1;

    // NOTE: every always_comb output gets a default before the case so that no
    // path leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_next_state = arbitrate(w_elig0, w_elig1, r_last_gnt);
            end
            ST_GRANT0: begin
                if (!req0) begin
                    w_next_state = arbitrate(1'b0, w_elig1, r_last_gnt);
                end else if (w_tc) begin
                    w_timeout    = 1'b1;
                    w_next_state = arbitrate(1'b0, w_elig1, r_last_gnt);
                end
            end
            ST_GRANT1: begin
                if (!req1) begin
                    w_next_state = arbitrate(w_elig0, 1'b0, r_last_gnt);
                end else if (w_tc) begin
                    w_timeout    = 1'b1;
                    w_next_state = arbitrate(w_elig0, 1'b0, r_last_gnt);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A change of owner, handoffs included, starts a fresh burst.
    assign w_timer_clear  = (w_next_state == ST_IDLE);
    assign w_timer_load   = (w_next_state != ST_IDLE) && (w_next_state != r_state);
    assign w_timer_enable = (w_next_state != ST_IDLE) && (w_next_state == r_state);

    burst_timer #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_load   (w_timer_load),
        .i_enable (w_timer_enable),
        .o_tc     (w_tc)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_block0   <= 1'b0;
            r_block1   <= 1'b0;
            r_last_gnt <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_timeout;

            if ((w_next_state == ST_GRANT0) && (r_state != ST_GRANT0)) begin
                r_last_gnt <= 1'b0;
            end else if ((w_next_state == ST_GRANT1) && (r_state != ST_GRANT1)) begin
                r_last_gnt <= 1'b1;
            end

            // A timed-out requester stays locked out until it drops req once.
            if (!req0) begin
                r_block0 <= 1'b0;
            end else if (w_timeout && (r_state == ST_GRANT0)) begin
                r_block0 <= 1'b1;
            end

            if (!req1) begin
                r_block1 <= 1'b0;
            end else if (w_timeout && (r_state == ST_GRANT1)) begin
                r_block1 <= 1'b1;
            end
        end
    end

    assign w_cmd0 = '{op: op0, src1: src1_0, src2: src2_0, dest: dest0};
    assign w_cmd1 = '{op: op1, src1: src1_1, src2: src2_1, dest: dest1};

    always_comb begin
        w_cmd = DP_CMD_NOP;
        unique case (r_state)
            ST_GRANT0: w_cmd = w_cmd0;
            ST_GRANT1: w_cmd = w_cmd1;
            default:   w_cmd = DP_CMD_NOP;
        endcase
    end

    assign op   = w_cmd.op;
    assign src1 = w_cmd.src1;
    assign src2 = w_cmd.src2;
    assign dest = w_cmd.dest;

    assign gnt0 = (r_state == ST_GRANT0);
    assign gnt1 = (r_state == ST_GRANT1);
    assign busy = gnt0 || gnt1;
    assign err  = r_err;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Self-checking bench for datapath_arbiter: directed vector table, hand-written
// timeout sequence, then randomized traffic against a behavioural model.
module tb_datapath_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [3:0] src1_0, src2_0, dest0, src1_1, src2_1, dest1;
    logic       gnt0, gnt1, busy, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    datapath_arbiter #(
        .MAX_BURST (MB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .src1_0 (src1_0),
        .src2_0 (src2_0),
        .dest0  (dest0),
        .src1_1 (src1_1),
        .src2_1 (src2_1),
        .dest1  (dest1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .dest   (dest),
        .busy   (busy),
        .err    (err)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic  rst;
        logic  req0;
        logic  req1;
        logic  g0;
        logic  g1;
        logic  e;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic q0, input logic q1,
                           input logic g0, input logic g1, input logic e, input string name);
        vec_t v;
        v.rst = r; v.req0 = q0; v.req1 = q1;
        v.g0 = g0; v.g1 = g1; v.e = e; v.name = name;
        vecs.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_owner;       // -1 none, else requester index
    int m_held;        // cycles the current owner has held the datapath
    bit m_blocked[2];
    int m_last;
    bit m_err;
    bit m_elig[2];     // eligibility seen at the most recent edge
    int wait_cnt[2];
    int run_len[2];

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_last = 1; m_err = 0;
        for (int i = 0; i < 2; i++) begin
            m_blocked[i] = 0; m_elig[i] = 0; wait_cnt[i] = 0; run_len[i] = 0;
        end
    endtask

    task automatic model_step(input bit r0, input bit r1);
        bit req[2];
        int nxt;
        bit timeout;
        req[0] = r0;
        req[1] = r1;
        for (int i = 0; i < 2; i++) m_elig[i] = req[i] && !m_blocked[i];
        timeout = 0;
        if (m_owner < 0) begin
            if (m_elig[0] && m_elig[1]) nxt = 1 - m_last;
            else if (m_elig[0])         nxt = 0;
            else if (m_elig[1])         nxt = 1;
            else                        nxt = -1;
        end else if (req[m_owner] && m_held < MB) begin
            nxt = m_owner;
        end else begin
            timeout = req[m_owner];
            nxt = m_elig[1 - m_owner] ? 1 - m_owner : -1;
        end
        for (int i = 0; i < 2; i++) if (!req[i]) m_blocked[i] = 0;
        if (timeout) m_blocked[m_owner] = 1;
        if (nxt < 0)             m_held = 0;
        else if (nxt == m_owner) m_held++;
        else begin
            m_held = 1;
            m_last = nxt;
        end
        m_owner = nxt;
        m_err   = timeout;
    endtask

    initial begin
        logic [14:0] exp_dp;
        int          g1_cnt;
        int          err_cnt;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd6; src1_0 = 4'd2; src2_0 = 4'd7; dest0 = 4'd3;
        op1 = 3'd1; src1_1 = 4'd5; src2_1 = 4'd9; dest1 = 4'd12;

        //       rst r0 r1  g0 g1 err
        add_vec(1, 0, 0,  0, 0, 0, "reset");
        add_vec(1, 0, 0,  0, 0, 0, "reset_hold");
        add_vec(0, 1, 0,  1, 0, 0, "grant_latency");
        add_vec(1, 0, 0,  0, 0, 0, "reset2");
        add_vec(0, 1, 1,  1, 0, 0, "tie_after_reset");
        add_vec(0, 1, 1,  1, 0, 0, "burst0_c2");
        add_vec(0, 1, 1,  1, 0, 0, "burst0_c3");
        add_vec(0, 0, 1,  0, 1, 0, "handoff_no_gap");
        add_vec(0, 0, 0,  0, 0, 0, "release_idle");
        add_vec(0, 1, 1,  1, 0, 0, "next_tie_to_0");
        add_vec(0, 0, 0,  0, 0, 0, "idle_a");
        add_vec(0, 0, 1,  0, 1, 0, "to1_c1");
        add_vec(0, 0, 1,  0, 1, 0, "to1_c2");
        add_vec(0, 0, 1,  0, 1, 0, "to1_c3");
        add_vec(0, 0, 1,  0, 1, 0, "to1_c4");
        add_vec(0, 0, 1,  0, 0, 1, "timeout_err");
        add_vec(0, 0, 1,  0, 0, 0, "blocked_a");
        add_vec(0, 0, 1,  0, 0, 0, "blocked_b");
        add_vec(0, 0, 1,  0, 0, 0, "blocked_c");
        add_vec(0, 0, 0,  0, 0, 0, "unblock_low");
        add_vec(0, 0, 1,  0, 1, 0, "regrant_after_unblock");
        add_vec(0, 0, 1,  0, 1, 0, "regrant_c2");
        add_vec(1, 0, 1,  0, 0, 0, "reset_mid_burst");
        add_vec(0, 1, 1,  1, 0, 0, "tie_after_reset2");
        add_vec(0, 0, 0,  0, 0, 0, "idle_b");
        add_vec(0, 1, 0,  1, 0, 0, "to0_c1");
        add_vec(0, 1, 1,  1, 0, 0, "to0_c2");
        add_vec(0, 1, 1,  1, 0, 0, "to0_c3");
        add_vec(0, 1, 1,  1, 0, 0, "to0_c4");
        add_vec(0, 1, 1,  0, 1, 1, "timeout_handoff");
        add_vec(0, 1, 1,  0, 1, 0, "after_handoff");
        add_vec(0, 0, 1,  0, 1, 0, "g1_c3");
        add_vec(0, 1, 1,  0, 1, 0, "g1_c4");
        add_vec(0, 1, 1,  1, 0, 1, "timeout1_to_0");
        add_vec(0, 0, 0,  0, 0, 0, "idle_c");
        add_vec(0, 1, 0,  1, 0, 0, "rr_g0");
        add_vec(0, 0, 1,  0, 1, 0, "drop_hands_to_1");
        add_vec(0, 1, 1,  0, 1, 0, "reraise_waits");
        add_vec(0, 1, 0,  1, 0, 0, "reraise_regrant");
        add_vec(0, 0, 0,  0, 0, 0, "idle_d");
        add_vec(0, 1, 0,  1, 0, 0, "max_c1");
        add_vec(0, 1, 0,  1, 0, 0, "max_c2");
        add_vec(0, 1, 0,  1, 0, 0, "max_c3");
        add_vec(0, 1, 0,  1, 0, 0, "max_c4");
        add_vec(0, 0, 0,  0, 0, 0, "drop_at_max_no_err");
        add_vec(0, 1, 0,  1, 0, 0, "no_block_after_drop");

        foreach (vecs[k]) begin
            rst  = vecs[k].rst;
            req0 = vecs[k].req0;
            req1 = vecs[k].req1;
            step();
            if (vecs[k].g0)      exp_dp = {3'd6, 4'd2, 4'd7, 4'd3};
            else if (vecs[k].g1) exp_dp = {3'd1, 4'd5, 4'd9, 4'd12};
            else                 exp_dp = '0;
            check({vecs[k].name, "_gnt0"}, 32'(gnt0), 32'(vecs[k].g0));
            check({vecs[k].name, "_gnt1"}, 32'(gnt1), 32'(vecs[k].g1));
            check({vecs[k].name, "_err"},  32'(err),  32'(vecs[k].e));
            check({vecs[k].name, "_busy"}, 32'(busy), 32'(vecs[k].g0 | vecs[k].g1));
            check({vecs[k].name, "_dp"},   32'({op, src1, src2, dest}), 32'(exp_dp));
        end

        // Hand-written: req1 held for 10 cycles yields exactly MB grants and one err.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0; req1 = 1'b1;
        g1_cnt = 0; err_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt1) g1_cnt++;
            if (err)  err_cnt++;
        end
        check("hold10_gnt1_cycles", 32'(g1_cnt), 32'(MB));
        check("hold10_err_pulses",  32'(err_cnt), 32'd1);
        check("hold10_still_low",   32'(gnt1), 32'd0);
        req1 = 1'b0;
        step();
        check("drop_one_cycle_gnt1", 32'(gnt1), 32'd0);
        req1 = 1'b1;
        step();
        check("reraise_gnt1", 32'(gnt1), 32'd1);

        // Randomized traffic against the model.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        model_reset();
        rst = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [14:0] exp_rand;
            if ($urandom_range(99) < 15) req0 = ~req0;
            if ($urandom_range(99) < 15) req1 = ~req1;
            rst    = ($urandom_range(999) == 0);
            op0    = 3'($urandom);
            op1    = 3'($urandom);
            src1_0 = 4'($urandom); src2_0 = 4'($urandom); dest0 = 4'($urandom);
            src1_1 = 4'($urandom); src2_1 = 4'($urandom); dest1 = 4'($urandom);
            step();
            if (rst) model_reset();
            else     model_step(req0, req1);

            if (m_owner == 0)      exp_rand = {op0, src1_0, src2_0, dest0};
            else if (m_owner == 1) exp_rand = {op1, src1_1, src2_1, dest1};
            else                   exp_rand = '0;

            check($sformatf("rand%0d_gnt", cyc), 32'({gnt1, gnt0}),
                  32'({m_owner == 1, m_owner == 0}));
            check($sformatf("rand%0d_err", cyc),  32'(err),  32'(m_err));
            check($sformatf("rand%0d_busy", cyc), 32'(busy), 32'(m_owner >= 0));
            check($sformatf("rand%0d_dp", cyc), 32'({op, src1, src2, dest}), 32'(exp_rand));
            check($sformatf("rand%0d_mutex", cyc), 32'(gnt0 & gnt1), 32'd0);

            run_len[0] = gnt0 ? run_len[0] + 1 : 0;
            run_len[1] = gnt1 ? run_len[1] + 1 : 0;
            check($sformatf("rand%0d_burst_len", cyc),
                  32'((run_len[0] > MB) || (run_len[1] > MB)), 32'd0);

            wait_cnt[0] = (m_elig[0] && !gnt0) ? wait_cnt[0] + 1 : 0;
            wait_cnt[1] = (m_elig[1] && !gnt1) ? wait_cnt[1] + 1 : 0;
            check($sformatf("rand%0d_fairness", cyc),
                  32'((wait_cnt[0] > MB + 1) || (wait_cnt[1] > MB + 1)), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 16, maximum consecutive granted cycles per burst (legal 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  datapath request from requester 0 (sample sequencer) / requester 1 (coefficient loader); held high for the whole burst.
REQ-005 op0 / op1  input  3 each  requester datapath opcode.
REQ-006 src1_0, src2_0, dest0 / src1_1, src2_1, dest1  input  4 each  requester register selects.
REQ-007 gnt0 / gnt1  output  1 each  registered grant; at most one high in any cycle.
REQ-008 op  output  3  opcode to shared datapath.
REQ-009 src1, src2, dest  output  4 each  register selects to shared datapath.
REQ-010 busy  output  1  high whenever gnt0 or gnt1 is high.
REQ-011 err  output  1  one-cycle pulse on burst timeout.

Function
REQ-012 FSM states IDLE, GRANT0, GRANT1; gnt0 is high exactly in GRANT0, gnt1 exactly in GRANT1.
REQ-013 IDLE: only req0 eligible -> GRANT0; only req1 eligible -> GRANT1; both eligible -> the requester not granted last; none -> stay IDLE.
REQ-014 Grant latency: request sampled high in IDLE gives grant on the next cycle.
REQ-015 GRANTn holds while reqn is high and the burst count is below MAX_BURST.
REQ-016 Burst ends when reqn is sampled low. Next state is GRANTm if the other requester m is eligible, otherwise IDLE. Direct handoff has no idle cycle.
REQ-017 Burst counter: 8-bit. Loads 1 on entry to any GRANT state and increments each granted cycle. It never wraps.
REQ-018 Timeout: in GRANTn with reqn high and count == MAX_BURST, the arbiter force-releases n, pulses err for one cycle and sets blockn. Next state follows the same rule as REQ-016.
REQ-019 Eligibility: reqn high and blockn low. blockn clears on the first cycle reqn is sampled low.
REQ-020 last_gnt updates to n on every entry into GRANTn and is used only for tie-break.
REQ-021 Output mux (combinational): in GRANTn, op/src1/src2/dest equal requester n's inputs. In IDLE they are all zero (NOP, R0).
REQ-022 Requester inputs are ignored while that requester is not granted.
REQ-023 Simultaneous timeout and req drop in the same cycle is treated as a normal release: no err, no block.
REQ-024 A requester that lowers and re-raises req mid-burst has ended its burst. It re-arbitrates from the next cycle with round-robin applied.

Reset
REQ-025 While rst is sampled high: state IDLE, gnt0=gnt1=0, busy=0, err=0, counter=0, block0=block1=0, last_gnt=1 (requester 0 wins the first tie).
REQ-026 Reset asserted mid-burst drops the grant on the next edge. The datapath outputs show NOP from that cycle on.

Structure
REQ-027 A shared package holds the state enum, the 3-bit opcode constants (NOP=0 … MUL=6) and the 4-bit register-select type. The datapath, the existing controller and this block all import it.
REQ-028 One sub-module: burst_timer (the counter of REQ-017 with clear, enable and terminal-count output). Arbitration FSM and output mux stay in datapath_arbiter.

Verification
REQ-029 req0 high at cycle 0, req1 low → gnt0=1 at cycle 1; op/src1/src2/dest mirror op0=6, src1_0=2, src2_0=7, dest0=3; busy=1.
REQ-030 req0 and req1 rise together after reset → gnt0 first. req0 drops after 3 grants → gnt1 on the next cycle with no IDLE gap. The next tie goes to 0.
REQ-031 MAX_BURST=4, req1 held high 10 cycles → gnt1 for exactly 4 cycles, then err=1 for one cycle and gnt1=0. gnt1 stays low until req1 is low one cycle and high again.
REQ-032 Timeout on requester 0 while req1 is high → err pulse and gnt1 in the same cycle the grant moves.
REQ-033 rst=1 during GRANT1 → next cycle gnt0=gnt1=busy=err=0 and op=0. After release, a tie grants requester 0.
REQ-034 Random req0/req1 for 10k cycles → assertions hold: never gnt0&gnt1; no grant longer than MAX_BURST; every eligible request is granted within MAX_BURST+1 cycles.
